// File: rtl/period_wave_gen.sv
// -----------------------------------------------------------------------------
// period_wave_gen
// Programmable rectangular-wave generator. Counts sys_count_clk cycles to build
// a wave of period P and high time H, either continuously or for a burst of N
// periods. Configuration is staged in shadow registers and only copied into the
// active registers at start and at period boundaries, so a period is never
// altered once it has begun.
//
// Ports
//   sys_count_clk : system clock, all logic on its rising edge
//   rst_n         : synchronous active-low reset
//   cfg_period    : period P in cycles (accepted only when P >= 2)
//   cfg_high      : high time H in cycles (saturated to P)
//   cfg_burst     : number of periods to generate, 0 = continuous
//   cfg_load      : strobe, capture cfg_* into the shadow registers
//   start         : strobe, begin generation from IDLE
//   stop          : strobe, abort generation
//   wave_out      : generated wave (registered)
//   period_tick   : pulse on the first cycle of each period
//   busy          : high while generating
//   done          : pulse at end of burst or after stop
//   cfg_err       : pulse for a rejected load or start
//   periods_done  : completed full periods since the last start
// -----------------------------------------------------------------------------
module period_wave_gen #(
  parameter int CNT_W   = 32,
  parameter int BURST_W = 16
) (
  input  logic               sys_count_clk,
  input  logic               rst_n,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [CNT_W-1:0]   cfg_high,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               cfg_load,
  input  logic               start,
  input  logic               stop,
  output logic               wave_out,
  output logic               period_tick,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [BURST_W-1:0] periods_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  // High time clipped to the period so H > P behaves as a constant-high wave.
  function automatic logic [CNT_W-1:0] sat_high(input logic [CNT_W-1:0] h,
                                                input logic [CNT_W-1:0] p);
    if (h > p) begin
      sat_high = p;
    end else begin
      sat_high = h;
    end
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   shd_p_q, shd_p_d, shd_h_q, shd_h_d;
  logic [BURST_W-1:0] shd_burst_q, shd_burst_d;
  logic [CNT_W-1:0]   act_p_q, act_p_d, act_h_q, act_h_d;
  logic [BURST_W-1:0] act_burst_q, act_burst_d;
  logic [BURST_W-1:0] periods_q, periods_d, periods_inc_s;
  logic               wave_q, wave_d, tick_q, tick_d, busy_q, busy_d;
  logic               done_q, done_d, err_q, err_d;
  logic               load_ok_s, start_err_s;

  // Next-state, shadow/active config and registered-output computation.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    act_p_d       = act_p_q;
    act_h_d       = act_h_q;
    act_burst_d   = act_burst_q;
    periods_d     = periods_q;
    start_err_s   = 1'b0;
    periods_inc_s = periods_q;

    load_ok_s = cfg_load && (cfg_period >= CNT_W'(2));
    if (load_ok_s) begin
      shd_p_d     = cfg_period;
      shd_h_d     = sat_high(cfg_high, cfg_period);
      shd_burst_d = cfg_burst;
    end else begin
      shd_p_d     = shd_p_q;
      shd_h_d     = shd_h_q;
      shd_burst_d = shd_burst_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (shd_p_q < CNT_W'(2)) begin
            start_err_s = 1'b1;
          end else if (!stop) begin
            state_d     = S_RUN;
            phase_d     = {CNT_W{1'b0}};
            periods_d   = {BURST_W{1'b0}};
            act_p_d     = shd_p_q;
            act_h_d     = shd_h_q;
            act_burst_d = shd_burst_q;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          // Partial period is not counted.
          state_d = S_FINISH;
        end else if (phase_q == act_p_q - CNT_W'(1)) begin
          if (periods_q == {BURST_W{1'b1}}) begin
            periods_inc_s = periods_q;
          end else begin
            periods_inc_s = periods_q + BURST_W'(1);
          end
          periods_d = periods_inc_s;
          if ((act_burst_q != {BURST_W{1'b0}}) && (periods_inc_s == act_burst_q)) begin
            state_d = S_FINISH;
          end else begin
            // Boundary: pick up the shadow value as it was before this edge.
            phase_d     = {CNT_W{1'b0}};
            act_p_d     = shd_p_q;
            act_h_d     = shd_h_q;
            act_burst_d = shd_burst_q;
          end
        end else begin
          phase_d = phase_q + CNT_W'(1);
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from next-state values so they line up with the
    // cycle the FSM is actually in.
    wave_d = (state_d == S_RUN) && (phase_d < act_h_d);
    tick_d = (state_d == S_RUN) && (phase_d == {CNT_W{1'b0}});
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_FINISH);
    err_d  = (cfg_load && !load_ok_s) || start_err_s;
  end

  // State, configuration and output registers with synchronous reset.
  always_ff @(posedge sys_count_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= {CNT_W{1'b0}};
      shd_p_q     <= {CNT_W{1'b0}};
      shd_h_q     <= {CNT_W{1'b0}};
      shd_burst_q <= {BURST_W{1'b0}};
      act_p_q     <= {CNT_W{1'b0}};
      act_h_q     <= {CNT_W{1'b0}};
      act_burst_q <= {BURST_W{1'b0}};
      periods_q   <= {BURST_W{1'b0}};
      wave_q      <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      shd_p_q     <= shd_p_d;
      shd_h_q     <= shd_h_d;
      shd_burst_q <= shd_burst_d;
      act_p_q     <= act_p_d;
      act_h_q     <= act_h_d;
      act_burst_q <= act_burst_d;
      periods_q   <= periods_d;
      wave_q      <= wave_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign wave_out     = wave_q;
  assign period_tick  = tick_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = err_q;
  assign periods_done = periods_q;

endmodule

// File: tb/tb_period_wave_gen.sv
// -----------------------------------------------------------------------------
// tb_period_wave_gen
// Directed bench for period_wave_gen. Expected per-cycle outputs are pushed to
// a scoreboard queue as stimulus is planned and popped one per clock, 1 time
// unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_period_wave_gen;

  localparam int CNT_W   = 32;
  localparam int BURST_W = 16;

  typedef struct packed {
    logic               wave;
    logic               tick;
    logic               busy;
    logic               done;
    logic               err;
    logic [BURST_W-1:0] pd;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic [CNT_W-1:0]   cfg_high = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic               cfg_load = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               wave_out, period_tick, busy, done, cfg_err;
  logic [BURST_W-1:0] periods_done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  period_wave_gen #(.CNT_W(CNT_W), .BURST_W(BURST_W)) dut (
    .sys_count_clk (clk),
    .rst_n         (rst_n),
    .cfg_period    (cfg_period),
    .cfg_high      (cfg_high),
    .cfg_burst     (cfg_burst),
    .cfg_load      (cfg_load),
    .start         (start),
    .stop          (stop),
    .wave_out      (wave_out),
    .period_tick   (period_tick),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err),
    .periods_done  (periods_done)
  );

  always #5 clk = ~clk;

  task automatic push_e(input logic w, input logic t, input logic b,
                        input logic d, input logic e, input int pd);
    exp_t x;
    x.wave = w; x.tick = t; x.busy = b; x.done = d; x.err = e;
    x.pd   = BURST_W'(pd);
    sb.push_back(x);
  endtask

  task automatic push_idle(input int pd);
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pd);
  endtask

  // One full period of length p with high time h, as seen from outside.
  task automatic push_period(input int p, input int h, input int pd);
    for (int i = 0; i < p; i++) begin
      push_e((i < h), (i == 0), 1'b1, 1'b0, 1'b0, pd);
    end
  endtask

  // Advance n clocks, comparing each cycle's outputs with the scoreboard head.
  task automatic ticks(input int n, input string tag);
    exp_t obs, want;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      obs = '{wave_out, period_tick, busy, done, cfg_err, periods_done};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL %s[%0d]: scoreboard empty, observed %h", tag, i, obs);
      end else begin
        want = sb.pop_front();
        assert (obs === want) else begin
          errors++;
          $error("FAIL %s[%0d]: observed w/t/b/d/e/pd=%b%b%b%b%b/%0d expected %b%b%b%b%b/%0d",
                 tag, i, obs.wave, obs.tick, obs.busy, obs.done, obs.err, obs.pd,
                 want.wave, want.tick, want.busy, want.done, want.err, want.pd);
        end
      end
    end
  endtask

  task automatic set_cfg(input int p, input int h, input int b);
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_burst  = BURST_W'(b);
  endtask

  initial begin
    // 1: reset held three cycles
    for (int i = 0; i < 3; i++) push_idle(0);
    ticks(3, "reset");
    rst_n = 1'b1;

    // 3: start with invalid (reset) shadow, then rejected load of P=1
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    push_idle(0);
    start = 1'b1; ticks(1, "start_invalid"); start = 1'b0;
    ticks(1, "start_invalid_after");
    set_cfg(1, 0, 0);
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    push_idle(0);
    cfg_load = 1'b1; ticks(1, "load_p1"); cfg_load = 1'b0;
    ticks(1, "load_p1_after");
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    start = 1'b1; ticks(1, "start_still_invalid"); start = 1'b0;

    // 2: burst of two periods P=10, H=3
    set_cfg(10, 3, 2);
    push_idle(0);
    cfg_load = 1'b1; ticks(1, "load_10_3"); cfg_load = 1'b0;
    push_period(10, 3, 0);
    push_period(10, 3, 1);
    push_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    push_idle(2);
    start = 1'b1; ticks(1, "burst_first"); start = 1'b0;
    ticks(21, "burst");

    // Rejected load keeps the 10/3 shadow; start then stop after one cycle
    set_cfg(1, 7, 0);
    push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    cfg_load = 1'b1; ticks(1, "load_p1_keep"); cfg_load = 1'b0;
    push_e(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    push_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    push_idle(0);
    start = 1'b1; ticks(1, "shadow_kept"); start = 1'b0;
    stop = 1'b1; ticks(1, "early_stop"); stop = 1'b0;
    ticks(1, "early_stop_idle");

    // 4: continuous 4/2 with mid-period and boundary-cycle loads
    set_cfg(4, 2, 0);
    push_idle(0);
    cfg_load = 1'b1; ticks(1, "load_4_2"); cfg_load = 1'b0;
    push_period(4, 2, 0);
    push_period(4, 2, 1);
    push_period(6, 6, 2);
    push_period(6, 6, 3);
    push_period(4, 1, 4);
    push_e(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    push_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    push_idle(5);
    start = 1'b1; ticks(1, "cont_start"); start = 1'b0;
    ticks(4, "cont_p1");
    set_cfg(6, 9, 0);
    cfg_load = 1'b1; ticks(1, "mid_load"); cfg_load = 1'b0;
    ticks(8, "cont_p2_p3");
    set_cfg(4, 1, 0);
    cfg_load = 1'b1; ticks(1, "boundary_load"); cfg_load = 1'b0;
    ticks(10, "cont_p4_p5");
    stop = 1'b1; ticks(1, "cont_stop"); stop = 1'b0;
    ticks(1, "cont_idle");

    // 5: continuous 10/5, stop at phase 5 of the third period
    set_cfg(10, 5, 0);
    push_idle(5);
    cfg_load = 1'b1; ticks(1, "load_10_5"); cfg_load = 1'b0;
    push_period(10, 5, 0);
    push_period(10, 5, 1);
    for (int i = 0; i < 6; i++) push_e((i < 5), (i == 0), 1'b1, 1'b0, 1'b0, 2);
    push_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    push_idle(2);
    start = 1'b1; ticks(1, "stop_run_start"); start = 1'b0;
    ticks(25, "stop_run");
    stop = 1'b1; ticks(1, "stop_finish"); stop = 1'b0;
    ticks(1, "stop_idle");
    push_idle(2);
    push_idle(2);
    start = 1'b1; stop = 1'b1; ticks(1, "start_and_stop");
    start = 1'b0; stop = 1'b0; ticks(1, "start_and_stop_after");

    // 6: reset during RUN phase 4, then restart with a one-period burst
    for (int i = 0; i < 5; i++) push_e((i < 5), (i == 0), 1'b1, 1'b0, 1'b0, 0);
    start = 1'b1; ticks(1, "rst_run_start"); start = 1'b0;
    ticks(4, "rst_run");
    push_idle(0);
    rst_n = 1'b0; ticks(1, "mid_run_reset"); rst_n = 1'b1;
    set_cfg(5, 2, 1);
    push_idle(0);
    cfg_load = 1'b1; ticks(1, "reload"); cfg_load = 1'b0;
    push_period(5, 2, 0);
    push_e(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
    push_idle(1);
    start = 1'b1; ticks(1, "restart"); start = 1'b0;
    ticks(6, "restart_run");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
